// File: rtl/net_pkg.sv
// net_pkg: protocol type codes and merge FSM states shared by the tx merge and rx split blocks.
package net_pkg;
    typedef enum logic [2:0] {
        NET_TYPE_NONE = 3'b000,
        NET_TYPE_ARP  = 3'b001,
        NET_TYPE_UDP  = 3'b010,
        NET_TYPE_ICMP = 3'b100
    } net_type_t;
    typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} merge_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; ptr is a one-hot marker of the highest-priority requester.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         upd,
    input  logic [N-1:0] last,
    output logic [N-1:0] gnt
);
    logic [N-1:0] ptr, masked, pick;
    // requesters at or above ptr win; otherwise wrap to the lowest requester
    assign masked = req & ~(ptr - N'(1));
    assign pick = |masked ? masked : req;
    assign gnt = pick & (~pick + N'(1));
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= N'(1);
        else if (upd)
            ptr <= {last[N-2:0], last[N-1]};
    end
endmodule

// File: rtl/frame_merge.sv
// frame_merge: frame-granular round-robin merge of ARP/UDP tx streams (ICMP too with FRAME_MERGE_ICMP_EN),
// with per-frame type tag, inter-frame gap and truncation at MAX_FRAME_LEN.
module frame_merge
    import net_pkg::*;
#(
    parameter int IFG_CYCLES    = 12,
    parameter int MAX_FRAME_LEN = 1500
) (
    input  logic       logic_clk,
    input  logic       logic_rst,
    input  logic [7:0] arp_tdata_in,
    input  logic       arp_tvalid_in,
    output logic       arp_tready_out,
    input  logic       arp_tlast_in,
`ifdef FRAME_MERGE_ICMP_EN
    input  logic [7:0] icmp_tdata_in,
    input  logic       icmp_tvalid_in,
    output logic       icmp_tready_out,
    input  logic       icmp_tlast_in,
`endif
    input  logic [7:0] udp_tdata_in,
    input  logic       udp_tvalid_in,
    output logic       udp_tready_out,
    input  logic       udp_tlast_in,
    output logic [7:0] net_tdata_out,
    output logic       net_tvalid_out,
    input  logic       net_tready_in,
    output logic       net_tlast_out,
    output logic [2:0] net_ttype_out,
    output logic       frame_err_out
);
`ifdef FRAME_MERGE_ICMP_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif
    localparam int CW = $clog2(MAX_FRAME_LEN + 1);
    // IDLE and the first SEND cycle are idle on the net side too, so they count toward the gap
    localparam int GAP_WAIT = IFG_CYCLES > 3 ? IFG_CYCLES - 3 : 0;
    localparam int GW = $clog2(GAP_WAIT + 1) + 1;

    merge_state_t  state;
    logic [N-1:0]  src_valid, src_last, src_ready, gnt, gnt_q;
    logic [7:0]    sel_data;
    net_type_t     gnt_type;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gap;
    logic          out_free, sel_valid, sel_last, take, to_gap, trunc;

`ifdef FRAME_MERGE_ICMP_EN
    assign src_valid = {udp_tvalid_in, icmp_tvalid_in, arp_tvalid_in};
    assign src_last = {udp_tlast_in, icmp_tlast_in, arp_tlast_in};
    assign {udp_tready_out, icmp_tready_out, arp_tready_out} = src_ready;
    assign sel_data = gnt_q[0] ? arp_tdata_in : gnt_q[1] ? icmp_tdata_in : udp_tdata_in;
    assign gnt_type = gnt[0] ? NET_TYPE_ARP : gnt[1] ? NET_TYPE_ICMP : NET_TYPE_UDP;
`else
    assign src_valid = {udp_tvalid_in, arp_tvalid_in};
    assign src_last = {udp_tlast_in, arp_tlast_in};
    assign {udp_tready_out, arp_tready_out} = src_ready;
    assign sel_data = gnt_q[0] ? arp_tdata_in : udp_tdata_in;
    assign gnt_type = gnt[0] ? NET_TYPE_ARP : NET_TYPE_UDP;
`endif

    assign out_free = !net_tvalid_out || net_tready_in;
    assign sel_valid = |(src_valid & gnt_q);
    assign sel_last = |(src_last & gnt_q);
    assign take = state == DRAIN || (state == SEND && out_free);
    assign src_ready = take ? gnt_q : '0;
    assign to_gap = take && sel_valid && sel_last;
    assign trunc = cnt == CW'(MAX_FRAME_LEN - 1);

    rr_arbiter #(.N(N)) u_arb (
        .clk (logic_clk),
        .rst (logic_rst),
        .req (src_valid),
        .upd (to_gap),
        .last(gnt_q),
        .gnt (gnt)
    );

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            state <= IDLE;
            gnt_q <= '0;
            cnt <= '0;
            gap <= '0;
            net_tdata_out <= '0;
            net_tvalid_out <= 1'b0;
            net_tlast_out <= 1'b0;
            net_ttype_out <= '0;
            frame_err_out <= 1'b0;
        end else begin
            frame_err_out <= 1'b0;
            if (net_tready_in)
                net_tvalid_out <= 1'b0;
            case (state)
                IDLE: begin
                    gap <= '0;
                    cnt <= '0;
                    if (|src_valid) begin
                        gnt_q <= gnt;
                        net_ttype_out <= gnt_type;
                        state <= SEND;
                    end
                end
                SEND: if (out_free) begin
                    net_tvalid_out <= sel_valid;
                    if (sel_valid) begin
                        net_tdata_out <= sel_data;
                        cnt <= cnt + CW'(1);
                        net_tlast_out <= sel_last || trunc;
                        frame_err_out <= !sel_last && trunc;
                        state <= sel_last ? GAP : trunc ? DRAIN : SEND;
                    end
                end
                DRAIN: if (to_gap)
                    state <= GAP;
                GAP: if (!net_tvalid_out) begin
                    gap <= gap + GW'(1);
                    if (gap >= GW'(GAP_WAIT))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
